// File: rtl/alu_datapath_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_datapath_pkg : opcodes, flag bit positions and sequencing states |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_datapath_pkg;

  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_AND = 4'b1011;
  localparam logic [3:0] OP_OR  = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b1101;
  localparam logic [3:0] OP_NOT = 4'b1110;
  localparam logic [3:0] OP_SHL = 4'b1111;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HAVE_A = 2'd1,
    ST_HAVE_B = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_datapath_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_core : combinational ALU producing result, carry/borrow, overflow |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_core
  import alu_datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic [OPW-1:0]   opcode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic [WIDTH:0] w_shl;

  // The extra top bit carries the carry-out, the borrow, or the last bit shifted out.
  assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
  assign w_diff = {1'b0, a_i} - {1'b0, b_i};
  assign w_shl  = {1'b0, a_i} << b_i[3:0];

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    ovf_o    = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        result_o = w_sum[WIDTH-1:0];
        carry_o  = w_sum[WIDTH];
        ovf_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        result_o = w_diff[WIDTH-1:0];
        carry_o  = w_diff[WIDTH];
        ovf_o    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOT:  result_o = ~a_i;
      OP_SHL: begin
        result_o = w_shl[WIDTH-1:0];
        carry_o  = w_shl[WIDTH];
      end
      default: result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_datapath : strobe-driven operand capture, compute and bus drive   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_datapath
  import alu_datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fullBitNum,
  input  logic             ALUin1,
  input  logic             ALUin2,
  input  logic             ALU_outlach,
  input  logic             ALU_outEN,
  input  logic             done,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic [3:0]       flags,
  output logic             err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [OPW-1:0]   opcode_q, opcode_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic             w_multi;
  logic             w_unused;

  assign w_unused = ^fullBitNum[WIDTH-OPW-1:0];

  alu_core #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_core (
    .opcode_i (opcode_q),
    .a_i      (opa_q),
    .b_i      (opb_q),
    .result_o (w_alu_res),
    .carry_o  (w_alu_c),
    .ovf_o    (w_alu_v)
  );

  assign w_multi = (ALUin1 & ALUin2) | (ALUin1 & ALU_outlach) | (ALUin2 & ALU_outlach);

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opcode_d = opcode_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = 1'b0;
    if (w_multi) begin
      err_d = 1'b1;
    end else if (ALUin1) begin
      opa_d    = bus_in;
      opcode_d = fullBitNum[WIDTH-1 -: OPW];
      state_d  = ST_HAVE_A;
    end else if (ALUin2) begin
      if (state_q == ST_HAVE_A || state_q == ST_HAVE_B) begin
        opb_d   = bus_in;
        state_d = ST_HAVE_B;
      end else begin
        err_d = 1'b1;
      end
    end else if (ALU_outlach) begin
      if (state_q == ST_HAVE_B || state_q == ST_RESULT) begin
        state_d = ST_RESULT;
        if (opcode_q < OP_ADD) begin
          result_d = '0;
          flags_d  = 4'b1000;
          err_d    = 1'b1;
        end else begin
          result_d       = w_alu_res;
          flags_d[FLG_Z] = (w_alu_res == '0);
          flags_d[FLG_N] = w_alu_res[WIDTH-1];
          flags_d[FLG_C] = w_alu_c;
          flags_d[FLG_V] = w_alu_v;
        end
      end else begin
        err_d = 1'b1;
      end
    end
    if (ALU_outEN && state_q != ST_RESULT) begin
      err_d = 1'b1;
    end
    // done overrides the next state and silences err, but data captured above stands.
    if (done) begin
      state_d = ST_IDLE;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      opcode_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  assign bus_oe  = ALU_outEN && (state_q == ST_RESULT);
  assign bus_out = bus_oe ? result_q : '0;
  assign flags   = flags_q;
  assign err     = err_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_datapath : directed plus random stimulus against a ref model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_datapath;

  logic        clk;
  logic        rst;
  logic [15:0] fullBitNum;
  logic        ALUin1, ALUin2, ALU_outlach, ALU_outEN, done;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic [3:0]  flags;
  logic        err;
  logic        busy;

  alu_datapath #(.WIDTH(16), .OPW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .fullBitNum  (fullBitNum),
    .ALUin1      (ALUin1),
    .ALUin2      (ALUin2),
    .ALU_outlach (ALU_outlach),
    .ALU_outEN   (ALU_outEN),
    .done        (done),
    .bus_in      (bus_in),
    .bus_out     (bus_out),
    .bus_oe      (bus_oe),
    .flags       (flags),
    .err         (err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_A = 1, M_B = 2, M_RES = 3;

  int n_cmp = 0;
  int n_bad = 0;
  int ms, mA, mB, mop, mres, mf, merr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_signed16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Reference ALU in plain integer arithmetic; returns result and {Z,N,C,V}.
  task automatic ref_alu(input int op, input int a, input int b, output int r, output int f);
    int c, v, s, ss, sh;
    longint p;
    c = 0; v = 0; r = 0;
    case (op)
      9: begin
        s = a + b; r = s % 65536; c = (s > 65535);
        ss = to_signed16(a) + to_signed16(b); v = (ss > 32767 || ss < -32768);
      end
      10: begin
        r = (a - b + 65536) % 65536; c = (a < b);
        ss = to_signed16(a) - to_signed16(b); v = (ss > 32767 || ss < -32768);
      end
      11: r = a & b;
      12: r = a | b;
      13: r = a ^ b;
      14: r = (~a) & 65535;
      15: begin
        sh = b % 16; p = longint'(a) << sh;
        r = int'(p % 65536); c = (sh == 0) ? 0 : int'((p >> 16) & 1);
      end
      default: r = 0;
    endcase
    if (op < 9) f = 8;
    else f = ((r == 0) ? 8 : 0) + ((r >= 32768) ? 4 : 0) + c * 2 + v;
  endtask

  task automatic model_reset();
    ms = M_IDLE; mA = 0; mB = 0; mop = 0; mres = 0; mf = 0; merr = 0;
  endtask

  task automatic model_clock();
    int nstrobe, ns, e;
    nstrobe = int'(ALUin1) + int'(ALUin2) + int'(ALU_outlach);
    ns = ms; e = 0;
    if (nstrobe > 1) e = 1;
    else if (ALUin1) begin
      mA = int'(bus_in); mop = int'(fullBitNum[15:12]); ns = M_A;
    end else if (ALUin2) begin
      if (ms == M_A || ms == M_B) begin mB = int'(bus_in); ns = M_B; end
      else e = 1;
    end else if (ALU_outlach) begin
      if (ms == M_B || ms == M_RES) begin
        ref_alu(mop, mA, mB, mres, mf);
        ns = M_RES;
        if (mop < 9) e = 1;
      end else e = 1;
    end
    if (ALU_outEN && ms != M_RES) e = 1;
    if (done) begin ns = M_IDLE; e = 0; end
    ms = ns; merr = e;
  endtask

  task automatic cyc(input bit a1, input bit a2, input bit lt, input bit oe, input bit dn,
                     input logic [15:0] bv, input logic [15:0] fb);
    ALUin1 = a1; ALUin2 = a2; ALU_outlach = lt; ALU_outEN = oe; done = dn;
    bus_in = bv; fullBitNum = fb;
    @(negedge clk);
    check("bus_oe", 32'(bus_oe), 32'(oe && ms == M_RES));
    check("bus_out", 32'(bus_out), (oe && ms == M_RES) ? mres : 0);
    @(posedge clk);
    model_clock();
    #1;
    ALUin1 = 0; ALUin2 = 0; ALU_outlach = 0; ALU_outEN = 0; done = 0;
    check("err", 32'(err), merr);
    check("flags", 32'(flags), mf);
    check("busy", 32'(busy), 32'(ms != M_IDLE));
  endtask

  task automatic run_op(input logic [15:0] fb, input logic [15:0] a, input logic [15:0] b);
    cyc(1, 0, 0, 0, 0, a, fb);
    cyc(0, 1, 0, 0, 0, b, fb);
    cyc(0, 0, 1, 0, 0, 16'h0, fb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] edges [6] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h000F};

  initial begin
    int k, op;
    bit a1, a2, lt, oe, dn;
    logic [15:0] bv, fb;
    rst = 1; fullBitNum = 0; bus_in = 0;
    ALUin1 = 0; ALUin2 = 0; ALU_outlach = 0; ALU_outEN = 0; done = 0;
    model_reset();
    @(posedge clk); #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_flags", 32'(flags), 0);
    check("rst_err", 32'(err), 0);
    check("rst_oe", 32'(bus_oe), 0);
    rst = 0;

    // 1: basic ADD driven onto the bus
    run_op(16'h9042, 16'h1234, 16'h0001);
    check("t1_flags", 32'(flags), 32'h0);
    ALU_outEN = 1; #1;
    check("t1_oe", 32'(bus_oe), 1);
    check("t1_bus", 32'(bus_out), 32'h1235);
    cyc(0, 0, 0, 1, 0, 16'h0, 16'h9042);

    // 2: signed overflow ADD, then borrowing SUB
    run_op(16'h9000, 16'h7FFF, 16'h0001);
    check("t2_add_flags", 32'(flags), 32'b0101);
    run_op(16'hA000, 16'h0005, 16'h0007);
    check("t2_sub_flags", 32'(flags), 32'b0110);
    ALU_outEN = 1; #1;
    check("t2_sub_bus", 32'(bus_out), 32'hFFFE);
    cyc(0, 0, 0, 1, 0, 16'h0, 16'hA000);

    // 3: SHL carry-out and NOT
    run_op(16'hF000, 16'h8001, 16'h0001);
    check("t3_shl_flags", 32'(flags), 32'b0010);
    cyc(0, 0, 0, 1, 0, 16'h0, 16'hF000);
    run_op(16'hE000, 16'h00FF, 16'h1234);
    check("t3_not_flags", 32'(flags), 32'b0100);
    ALU_outEN = 1; #1;
    check("t3_not_bus", 32'(bus_out), 32'hFF00);
    cyc(0, 0, 0, 1, 0, 16'h0, 16'hE000);

    // 4: protocol violations
    cyc(0, 0, 0, 0, 1, 16'h0, 16'h0);
    cyc(0, 1, 0, 0, 0, 16'hAAAA, 16'h0);
    check("t4_in2_idle_err", 32'(err), 1);
    check("t4_in2_idle_busy", 32'(busy), 0);
    cyc(1, 0, 0, 0, 0, 16'h0003, 16'h9000);
    cyc(0, 1, 0, 0, 0, 16'h0004, 16'h9000);
    cyc(0, 0, 0, 1, 0, 16'h0, 16'h9000);
    check("t4_oen_hb_err", 32'(err), 1);
    cyc(1, 1, 0, 0, 0, 16'h5555, 16'hB000);
    check("t4_multi_err", 32'(err), 1);
    cyc(0, 0, 1, 0, 0, 16'h0, 16'h0);
    check("t4_after_multi_flags", 32'(flags), 32'h0);

    // 5: restart from RESULT
    run_op(16'h9000, 16'h0002, 16'h0003);
    cyc(1, 0, 0, 0, 0, 16'h0010, 16'hC000);
    ALU_outEN = 1; #1;
    check("t5_oe_after_restart", 32'(bus_oe), 0);
    cyc(0, 0, 0, 1, 0, 16'h0, 16'hC000);
    check("t5_restart_err", 32'(err), 1);
    cyc(0, 1, 0, 0, 0, 16'h0101, 16'h0);
    cyc(0, 0, 1, 0, 0, 16'h0, 16'h0);

    // 6: async reset mid-operation, then done in RESULT
    cyc(1, 0, 0, 0, 0, 16'h1111, 16'h9000);
    cyc(0, 1, 0, 0, 0, 16'h2222, 16'h9000);
    #2; rst = 1; #1;
    model_reset();
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_flags", 32'(flags), 0);
    check("t6_rst_err", 32'(err), 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    cyc(0, 0, 1, 0, 0, 16'h0, 16'h0);
    check("t6_latch_after_rst_err", 32'(err), 1);
    run_op(16'h9000, 16'hFFFF, 16'h0001);
    check("t6_wrap_flags", 32'(flags), 32'b1010);
    cyc(0, 0, 0, 0, 1, 16'h0, 16'h0);
    check("t6_done_busy", 32'(busy), 0);
    check("t6_done_flags", 32'(flags), 32'b1010);

    // 7: invalid opcode at compute
    run_op(16'h3000, 16'h1234, 16'h4321);
    check("t7_bad_op_err", 32'(err), 1);
    check("t7_bad_op_flags", 32'(flags), 32'b1000);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 99);
      a1 = 0; a2 = 0; lt = 0; dn = 0;
      if (k < 22) a1 = 1;
      else if (k < 44) a2 = 1;
      else if (k < 66) lt = 1;
      else if (k < 72) begin a1 = 1; a2 = ($urandom_range(0, 1) == 1); lt = !a2; end
      else if (k < 75) begin a2 = 1; lt = 1; end
      else if (k < 80) dn = 1;
      oe = ($urandom_range(0, 3) == 0);
      bv = ($urandom_range(0, 4) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
      op = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : $urandom_range(9, 15);
      fb = {4'(op), 12'($urandom)};
      cyc(a1, a2, lt, oe, dn, bv, fb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
